// File: rtl/ctrl_pkg.sv
// Shared control-unit constants: arbiter FSM state encodings and requester identifiers.
package ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; purely combinational, history register lives in the caller.
module rr_arb2
    import ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       win_id,
    output logic       win_valid
);

    always_comb begin
        win_valid = |req;
        win_id    = REQ_CPU;
        // On a tie the requester that did not win last time takes the bus.
        if (&req) begin
            win_id = ~last_gnt;
        end else if (req[1]) begin
            win_id = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port memory between the CPU sequencer and the loader/debug port,
// one fixed-latency access per grant, all outputs registered.
module mem_bus_arbiter
    import ctrl_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_gnt;
    logic          own;
    logic          own_we;
    logic          win_id;
    logic          win_valid;

    rr_arb2 u_rr_arb2 (
        .req       ({ldr_req, cpu_req}),
        .last_gnt  (last_gnt),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_gnt  <= REQ_LDR;
            own       <= REQ_CPU;
            own_we    <= 1'b0;
            cpu_gnt   <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_gnt   <= 1'b0;
            ldr_ack   <= 1'b0;
            ldr_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        own      <= win_id;
                        last_gnt <= win_id;
                        mem_en   <= 1'b1;
                        state    <= ST_ISSUE;
                        if (win_id == REQ_LDR) begin
                            ldr_gnt   <= 1'b1;
                            own_we    <= ldr_we;
                            mem_we    <= ldr_we;
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                        end else begin
                            cpu_gnt   <= 1'b1;
                            own_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= CW'(MEM_LAT - 1);
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Final WAIT cycle is the one where mem_rdata is valid.
                    if (cnt == '0) begin
                        state <= ST_ACK;
                        if (own == REQ_LDR) begin
                            ldr_ack <= 1'b1;
                            if (!own_we) ldr_rdata <= mem_rdata;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!own_we) cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    cpu_gnt <= 1'b0;
                    ldr_gnt <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed table, corner sequences, MEM_LAT=3 build, random vs timestamp model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       cpu_req, cpu_we, cpu_gnt, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       ldr_req, ldr_we, ldr_gnt, ldr_ack;
    logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic       x_cpu_req, x_cpu_we, x_cpu_gnt, x_cpu_ack;
    logic [7:0] x_cpu_addr, x_cpu_wdata, x_cpu_rdata;
    logic       x_ldr_req, x_ldr_we, x_ldr_gnt, x_ldr_ack;
    logic [7:0] x_ldr_addr, x_ldr_wdata, x_ldr_rdata;
    logic       x_mem_en, x_mem_we;
    logic [7:0] x_mem_addr, x_mem_wdata, x_mem_rdata;

    mem_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(x_cpu_req), .cpu_we(x_cpu_we), .cpu_addr(x_cpu_addr), .cpu_wdata(x_cpu_wdata),
        .cpu_gnt(x_cpu_gnt), .cpu_ack(x_cpu_ack), .cpu_rdata(x_cpu_rdata),
        .ldr_req(x_ldr_req), .ldr_we(x_ldr_we), .ldr_addr(x_ldr_addr), .ldr_wdata(x_ldr_wdata),
        .ldr_gnt(x_ldr_gnt), .ldr_ack(x_ldr_ack), .ldr_rdata(x_ldr_rdata),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
        .mem_rdata(x_mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h12) return 8'hA5;
        if (a == 8'h05) return 8'h33;
        return (a * 8'd3) ^ 8'h5C;
    endfunction

    // Memory for the MEM_LAT=1 build; data outside the valid window reads as 0xEE.
    logic [7:0]   mem1 [256];
    logic [255:0] wr1;
    logic         p1_v;
    logic [7:0]   p1_d;
    always @(posedge clk) begin
        if (!rst_n) begin
            wr1  <= '0;
            p1_v <= 1'b0;
        end else begin
            if (mem_en && mem_we) begin
                mem1[mem_addr] <= mem_wdata;
                wr1[mem_addr]  <= 1'b1;
            end
            p1_v <= mem_en && !mem_we;
            p1_d <= wr1[mem_addr] ? mem1[mem_addr] : init_val(mem_addr);
        end
    end
    assign mem_rdata = p1_v ? p1_d : 8'hEE;

    // Read-only memory for the MEM_LAT=3 build.
    logic [2:0] p3_v;
    logic [7:0] p3_d [3];
    always @(posedge clk) begin
        if (!rst_n) begin
            p3_v <= '0;
        end else begin
            p3_v    <= {p3_v[1:0], x_mem_en && !x_mem_we};
            p3_d[0] <= init_val(x_mem_addr);
            p3_d[1] <= p3_d[0];
            p3_d[2] <= p3_d[1];
        end
    end
    assign x_mem_rdata = p3_v[2] ? p3_d[2] : 8'hEE;

    logic [37:0] outs1, xouts;
    assign outs1 = {cpu_gnt, cpu_ack, cpu_rdata, ldr_gnt, ldr_ack, ldr_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata};
    assign xouts = {x_cpu_gnt, x_cpu_ack, x_cpu_rdata, x_ldr_gnt, x_ldr_ack, x_ldr_rdata,
                    x_mem_en, x_mem_we, x_mem_addr, x_mem_wdata};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ldr(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        ldr_req = r; ldr_we = w; ldr_addr = a; ldr_wdata = d;
    endtask

    typedef struct {
        logic       creq, cwe;
        logic [7:0] caddr, cwd;
        logic       lreq, lwe;
        logic [7:0] laddr, lwd;
        logic       win;        // 0 = CPU, 1 = LDR
        logic       ewe;
        logic [7:0] eaddr, ewd, erd;
    } vec_t;

    // Transaction-level reference model: timestamps of the current grant, no state machine.
    localparam int ML = 1;
    int         e;
    logic       m_busy, m_own, m_last, m_we;
    int         m_g;
    logic [7:0] m_addr, m_wd, m_rd;
    logic [7:0] exp_rd [2];
    logic [7:0] ref_mem [256];

    task automatic model_step();
        if ((!m_busy || e >= m_g + ML + 3) && (cpu_req || ldr_req)) begin
            if (cpu_req && ldr_req) m_own = ~m_last;
            else                    m_own = ldr_req;
            m_last = m_own;
            m_g    = e;
            m_busy = 1'b1;
            m_we   = m_own ? ldr_we    : cpu_we;
            m_addr = m_own ? ldr_addr  : cpu_addr;
            m_wd   = m_own ? ldr_wdata : cpu_wdata;
            if (m_we) ref_mem[m_addr] = m_wd;
            else      m_rd = ref_mem[m_addr];
        end
        if (m_busy && e == m_g + ML + 1 && !m_we) exp_rd[m_own] = m_rd;
    endtask

    function automatic logic [37:0] model_outs();
        logic g, a, en;
        g  = m_busy && e >= m_g && e <= m_g + ML + 1;
        a  = m_busy && e == m_g + ML + 1;
        en = m_busy && e == m_g;
        return {!m_own && g, !m_own && a, exp_rd[0], m_own && g, m_own && a, exp_rd[1],
                en, en && m_we, m_addr, m_wd};
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [7];
        vec_t       v;
        logic [7:0] pc, pl, exp_c, exp_l;
        int         nack, both, ack_cyc, waitn, xl;
        int         ack_own [4];
        int         ack_at  [4];

        vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h3F, 8'h7E, 1'b1, 1'b1, 8'h3F, 8'h7E, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b1, 1'b0, 8'h3F, 8'h00, 8'h7E};
        vecs[4] = '{1'b1, 1'b1, 8'h12, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h5A, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12, 8'h00, 8'h5A};
        vecs[6] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 8'h5A};

        rst_n = 1'b0;
        x_cpu_req = 1'b0; x_cpu_we = 1'b0; x_cpu_addr = '0; x_cpu_wdata = '0;
        x_ldr_req = 1'b0; x_ldr_we = 1'b0; x_ldr_addr = '0; x_ldr_wdata = '0;

        // Reset with both requests pending, then reset again mid-WAIT.
        set_cpu(1'b1, 1'b0, 8'h12, 8'h00);
        set_ldr(1'b1, 1'b0, 8'h3F, 8'h00);
        tick();
        chk("reset_outs_c1", 64'(outs1), 64'(0));
        tick();
        chk("reset_outs_c2", 64'(outs1), 64'(0));
        chk("reset_outs_lat3", 64'(xouts), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("first_grant_cpu", 64'({cpu_gnt, ldr_gnt, mem_en, mem_addr}), 64'({3'b101, 8'h12}));
        tick();
        chk("in_wait", 64'({cpu_gnt, ldr_gnt, mem_en, cpu_ack}), 64'(4'b1000));
        rst_n = 1'b0;
        tick();
        chk("reset_in_wait", 64'(outs1), 64'(0));
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("no_ack_after_reset", 64'(outs1), 64'(0));

        // Directed single transactions, round robin state carried row to row.
        for (int i = 0; i < 7; i++) begin
            v  = vecs[i];
            pc = cpu_rdata;
            pl = ldr_rdata;
            set_cpu(v.creq, v.cwe, v.caddr, v.cwd);
            set_ldr(v.lreq, v.lwe, v.laddr, v.lwd);
            tick();
            chk($sformatf("row%0d_gnt", i), 64'({cpu_gnt, ldr_gnt}), 64'(v.win ? 2'b01 : 2'b10));
            chk($sformatf("row%0d_issue", i), 64'({mem_en, mem_we, mem_addr, mem_wdata}),
                64'({1'b1, v.ewe, v.eaddr, v.ewd}));
            set_cpu(1'b0, 1'b1, 8'hFF, 8'hFF);
            set_ldr(1'b0, 1'b1, 8'hFF, 8'hFF);
            tick();
            chk($sformatf("row%0d_wait", i),
                64'({cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_en, mem_we, mem_addr}),
                64'({(v.win ? 2'b01 : 2'b10), 4'b0000, v.eaddr}));
            tick();
            chk($sformatf("row%0d_ack", i), 64'({cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_addr}),
                64'({(v.win ? 4'b0101 : 4'b1010), v.eaddr}));
            exp_c = (!v.win && !v.ewe) ? v.erd : pc;
            exp_l = ( v.win && !v.ewe) ? v.erd : pl;
            chk($sformatf("row%0d_rdata", i), 64'({cpu_rdata, ldr_rdata}), 64'({exp_c, exp_l}));
            tick();
            chk($sformatf("row%0d_idle", i), 64'({cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_en}), 64'(0));
        end

        // Continuous contention: alternating grants, one access per 4 cycles.
        set_cpu(1'b1, 1'b0, 8'h12, 8'h00);
        set_ldr(1'b1, 1'b0, 8'h3F, 8'h00);
        nack = 0;
        both = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            tick();
            if (cpu_gnt && ldr_gnt) both++;
            if (cpu_ack || ldr_ack) begin
                ack_own[nack] = ldr_ack ? 1 : 0;
                ack_at[nack]  = c;
                nack++;
            end
        end
        chk("contention_ack_count", 64'(nack), 64'(4));
        for (int i = 0; i < nack; i++) begin
            chk($sformatf("contention_owner%0d", i), 64'(ack_own[i]), 64'(i % 2));
            if (i > 0) chk($sformatf("contention_gap%0d", i), 64'(ack_at[i] - ack_at[i-1]), 64'(4));
        end
        chk("contention_both_gnt", 64'(both), 64'(0));
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 6; c++) tick();

        // CPU drops its request during WAIT; the access must still complete once.
        set_cpu(1'b1, 1'b0, 8'h12, 8'h00);
        tick();
        tick();
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        nack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack) nack++;
        end
        chk("abort_ack_count", 64'(nack), 64'(1));
        chk("abort_rdata", 64'(cpu_rdata), 64'(8'h5A));

        // MEM_LAT=3 build: read 0x05.
        x_cpu_req = 1'b1; x_cpu_we = 1'b0; x_cpu_addr = 8'h05; x_cpu_wdata = 8'h00;
        tick();
        chk("lat3_issue", 64'({x_cpu_gnt, x_mem_en, x_mem_we, x_mem_addr}), 64'({3'b110, 8'h05}));
        x_cpu_req = 1'b0;
        ack_cyc = -1;
        waitn   = 0;
        nack    = 0;
        xl      = 0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (x_cpu_ack) begin
                nack++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            if (x_cpu_gnt && !x_cpu_ack && !x_mem_en) waitn++;
            if (x_ldr_gnt || x_ldr_ack) xl++;
        end
        chk("lat3_ack_cycle", 64'(ack_cyc), 64'(5));
        chk("lat3_ack_count", 64'(nack), 64'(1));
        chk("lat3_wait_len", 64'(waitn), 64'(3));
        chk("lat3_rdata", 64'(x_cpu_rdata), 64'(8'h33));
        chk("lat3_ldr_idle", 64'(xl), 64'(0));

        // Random phase against the timestamp model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
        e = 0; m_busy = 1'b0; m_g = 0; m_own = 1'b0; m_last = 1'b1; m_we = 1'b0;
        m_addr = '0; m_wd = '0; m_rd = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            e++;
            model_step();
            #1;
            chk("rand_outputs", 64'(outs1), 64'(model_outs()));
            // CPU requester
            if (cpu_req) begin
                if (m_busy && !m_own && e == m_g + ML + 1) cpu_req = 1'b0;
                else if (m_busy && !m_own && e >= m_g && e <= m_g + ML + 1 && $urandom_range(7) == 0)
                    cpu_req = 1'b0;
                if (m_busy && !m_own && e >= m_g && e <= m_g + ML + 1) begin
                    cpu_we = 1'($urandom()); cpu_addr = 8'($urandom()); cpu_wdata = 8'($urandom());
                end
            end else if ($urandom_range(2) == 0) begin
                set_cpu(1'b1, 1'($urandom()), 8'($urandom()) | 8'h80, 8'($urandom()));
            end
            // LDR requester
            if (ldr_req) begin
                if (m_busy && m_own && e == m_g + ML + 1) ldr_req = 1'b0;
                else if (m_busy && m_own && e >= m_g && e <= m_g + ML + 1 && $urandom_range(7) == 0)
                    ldr_req = 1'b0;
                if (m_busy && m_own && e >= m_g && e <= m_g + ML + 1) begin
                    ldr_we = 1'($urandom()); ldr_addr = 8'($urandom()); ldr_wdata = 8'($urandom());
                end
            end else if ($urandom_range(2) == 0) begin
                set_ldr(1'b1, 1'($urandom()), 8'($urandom()) | 8'h80, 8'($urandom()));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
